// File: rtl/bit_serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU slice.
// Optional subtraction on op=11 is enabled by defining BIT_SERIAL_ALU_SUB_EN.
package bit_serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/bit_serial_alu_bit_slice.sv
// One-bit combinational datapath for bit_serial_alu.
// Macro BIT_SERIAL_ALU_SUB_EN adds operand inversion for op=11.
module alu_bit_slice
    import bit_serial_alu_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  op_e  op,
    output logic s,
    output logic cout
);

    logic ye;

`ifdef BIT_SERIAL_ALU_SUB_EN
    assign ye = (op == OP_SUB) ? ~y : y;
`else
    assign ye = y;
`endif

    always_comb begin
        s    = 1'b0;
        cout = 1'b0;
        unique case (op)
            OP_AND: s = x & y;
            OP_OR:  s = x | y;
            default: begin
                s    = x ^ ye ^ cin;
                cout = (x & ye) | (cin & (x ^ ye));
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: LSB-first, one bit per clock through alu_bit_slice.
// Macro BIT_SERIAL_ALU_SUB_EN turns op=11 into A-B; otherwise it is ADD.
module bit_serial_alu
    import bit_serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    state_e           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nx;
    logic             cy;
    op_e              op_q;
    logic             accept;
    logic             last;
    logic             cy_init;
    logic             s;
    logic             cout;

    assign busy   = (state == ST_SHIFT);
    assign done   = (state == ST_DONE);
    assign accept = start && (state != ST_SHIFT);
    assign last   = busy && (cnt == LAST);
    assign r_nx   = {s, r_sh[WIDTH-1:1]};

`ifdef BIT_SERIAL_ALU_SUB_EN
    assign cy_init = (op_e'(op) == OP_SUB);
`else
    assign cy_init = 1'b0;
`endif

    alu_bit_slice u_slice (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (cy),
        .op   (op_q),
        .s    (s),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST) state_nx = ST_DONE;
            ST_DONE:  state_nx = start ? ST_SHIFT : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            cy        <= 1'b0;
            op_q      <= OP_AND;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            op_q <= op_e'(op);
            cnt  <= '0;
            cy   <= cy_init;
        end else if (busy) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_nx;
            cnt  <= cnt + 1'b1;
            // logic ops never touch the carry, so it stays at its 0 preload
            if (op_q[1]) cy <= cout;
            if (last) begin
                result    <= r_nx;
                carry_out <= op_q[1] & cout;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu at WIDTH=8.
module tb_bit_serial_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        int           acc;
        string        name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive at a negedge; the next posedge is the accepting edge cyc+1
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [1:0] iop, input logic [W-1:0] er,
                         input logic ec, input string nm);
        exp_t e;
        a = ia;
        b = ib;
        op = iop;
        start = 1'b1;
        e.r = er;
        e.c = ec;
        e.acc = cyc + 1;
        e.name = nm;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) check({nm, "_idle_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && done) begin
                        if (q.size() == 0) begin
                            check("unexpected_done", 1, 0);
                        end else begin
                            e = q.pop_front();
                            check({e.name, "_result"}, int'(result), int'(e.r));
                            check({e.name, "_carry"}, int'(carry_out), int'(e.c));
                            check({e.name, "_latency"}, cyc - e.acc, W);
                        end
                    end
                end
            end
            begin : stim
                repeat (2) @(negedge clk);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_result", int'(result), 0);
                check("rst_carry", int'(carry_out), 0);
                rst_n = 1'b1;
                @(negedge clk);

                issue(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, "and");
                check("and_busy", int'(busy), 1);
                wait_done("and");
                @(negedge clk);
                check("and_idle_after_done", int'(busy | done), 0);
                wait_idle("and");

                issue(8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, "add_ff");
                wait_done("add_ff");
                issue(8'h12, 8'h34, 2'b01, 8'h36, 1'b0, "or_b2b");
                check("b2b_busy", int'(busy), 1);
                wait_done("or_b2b");
                wait_idle("or_b2b");

                issue(8'h55, 8'hAA, 2'b10, 8'hFF, 1'b0, "add_ign");
                @(negedge clk);
                a = 8'h00;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("ign_busy", int'(busy), 1);
                wait_done("add_ign");
                wait_idle("add_ign");

`ifdef BIT_SERIAL_ALU_SUB_EN
                issue(8'h05, 8'h07, 2'b11, 8'hFE, 1'b0, "sub_neg");
                wait_done("sub_neg");
                wait_idle("sub_neg");
                issue(8'h07, 8'h05, 2'b11, 8'h02, 1'b1, "sub_pos");
`else
                issue(8'h05, 8'h07, 2'b11, 8'h0C, 1'b0, "op3_add");
                wait_done("op3_add");
                wait_idle("op3_add");
                issue(8'h07, 8'h05, 2'b11, 8'h0C, 1'b0, "op3_add2");
`endif
                wait_done("op3");
                wait_idle("op3");

                issue(8'h0F, 8'h01, 2'b10, 8'h10, 1'b0, "abort");
                repeat (3) @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("abort_busy", int'(busy), 0);
                check("abort_done", int'(done), 0);
                check("abort_result", int'(result), 0);
                check("abort_carry", int'(carry_out), 0);
                q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                issue(8'h01, 8'h01, 2'b10, 8'h02, 1'b0, "post_rst");
                wait_done("post_rst");
                wait_idle("post_rst");
                repeat (3) @(negedge clk);
                check("queue_empty", q.size(), 0);
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
